pattern_scheduler: RTL
======================

# pattern_scheduler

Selects which of several test-pattern generators drives the monitor-tester RGB output, and when the selection changes. It advances the active pattern on a debounced push-button press or automatically every N frames. Selection changes only at frame boundaries, so no frame is ever torn. It sits between the VGA timing generator and the pattern generators, which include the colour-bar generator, on the FPGA monitor-tester board.

## Interface
- NUM_PATTERNS, 4, number of pattern sources; legal range 2..8.
- FRAMES_PER_PATTERN, 60, frames each pattern is shown in auto mode; must be ≥1.
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles before a button level is accepted (10 ms at 25 MHz).
- SEL_W, $clog2(NUM_PATTERNS), width of the select output.
- clk  in  1  pixel clock; the only clock.
- rst_n  in  1  reset, synchronous, active-low.
- frame_start  in  1  one-cycle pulse from the timing generator, coincident with pixel (0,0).
- de  in  1  visible-area enable from the timing generator.
- btn_next  in  1  raw push button, asynchronous, active-high.
- auto_en  in  1  level input; 1 selects auto-advance.
- pat_rgb  in  12*NUM_PATTERNS  source i occupies bits [12i+11:12i] as {r[3:0],g[3:0],b[3:0]}.
- rgb_out  out  12  registered pixel colour.
- pat_sel  out  SEL_W  index of the pattern active in the current frame.
- sel_change  out  1  one-cycle pulse in the first cycle a new selection is active.

## Operation
- **States:**
  - WAIT_SYNC: entered at reset. Output is forced black. Moves to RUN on the first frame_start.
  - RUN: the only other state. There is no exit except reset.
- **Button path:**
  - Two-flop synchroniser on btn_next, then the btn_debounce sub-module.
  - The debounced level changes only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
  - A rising edge of the debounced level is a "press".
- **Pending flag:**
  - Set by a press in RUN, or in auto mode (auto_en=1) when the frame counter equals FRAMES_PER_PATTERN-1 at frame_start.
  - Multiple presses within one frame collapse into a single advance.
  - A press and an auto terminal count in the same frame give a single advance.
- **Advance:**
  - Happens at frame_start while pending=1 (or while the auto terminal count is met at that same frame_start).
  - pat_sel becomes pat_sel+1, wrapping from NUM_PATTERNS-1 to 0.
  - pending clears, frame_cnt clears, sel_change pulses.
- **Frame counter:**
  - frame_cnt increments at each frame_start in RUN while auto_en=1.
  - It is held at 0 while auto_en=0.
  - It clears on every advance, including a manual one.
- **Output mux:**
  - In RUN, rgb_out = de ? pat_rgb[effective_sel] : 12'h000.
  - In WAIT_SYNC, rgb_out = 12'h000.
- **Presses in WAIT_SYNC** are ignored; they never set pending.

## Timing
- **Reset values** (rst_n=0 at a clk edge): rgb_out=0, pat_sel=0, sel_change=0, pending=0, frame_cnt=0, debounce state=0, synchroniser=0, state=WAIT_SYNC.
- **Pixel latency:** de and pat_rgb sampled at edge t appear on rgb_out after edge t+1. The timing generator delays hsync/vsync by 1 cycle to match.
- **effective_sel:**
  - Equals pat_sel, except in a frame_start cycle that advances. There it is the incremented value, so pixel (0,0) of the new frame already uses the new pattern.
  - pat_sel updates at that same edge.
  - sel_change is high for exactly the cycle after that edge.
- **Button press to advance:** 2 sync cycles + DEBOUNCE_CYCLES + 1 edge-detect cycle to set pending, then wait for the next frame_start.
- **Reset mid-frame** returns to WAIT_SYNC and discards the pending advance. Black is output until the next frame_start.
- **auto_en falling mid-frame** clears frame_cnt at the next edge. A pending flag that is already set still advances.

## Structure
- **Shared header:**
  - RGB_W=12.
  - Pattern index constants: PAT_BARS=0, PAT_CHECKER=1, PAT_GRAD=2, PAT_SOLID=3.
  - State encodings: WAIT_SYNC, RUN.
- **Sub-module btn_debounce:** synchroniser, counter and stable level. Parameter DEBOUNCE_CYCLES; outputs level and a one-cycle press pulse.
- **Top level:** FSM, pending flag, frame counter and output mux. Target 150–250 lines in total.

## Test plan
All scenarios use FRAMES_PER_PATTERN=3, DEBOUNCE_CYCLES=4 and frames of 100 cycles.

1. **Reset and first frame:** hold rst_n=0 for 5 cycles, de=1, source 0 = 12'hFFF. Expect rgb_out=0 and pat_sel=0 until the first frame_start. Expect rgb_out=12'hFFF one cycle after it.
2. **Manual advance:** auto_en=0, clean btn_next pulse of 10 cycles mid-frame. Expect pat_sel 0→1 at the next frame_start edge, sel_change high for 1 cycle, and the source-1 colour on the (0,0) pixel.
3. **Bounce rejection and collapsing:**
   - btn_next toggling every 2 cycles for 20 cycles: no advance.
   - Three clean presses in one frame: exactly one advance.
4. **Auto mode and wrap:** auto_en=1, no button. pat_sel goes 0→1→2→3→0 at frames 3, 6, 9, 12, with sel_change once per advance.
5. **Simultaneous events:** auto_en=1, press completing in frame 2 (the terminal count). Expect a single advance at frame 3 and frame_cnt=0 afterwards.
6. **Reset mid-operation:** pending=1, pat_sel=2, assert rst_n for 1 cycle mid-frame. Expect pat_sel=0, black output, and no advance at the next frame_start.

Source files
------------

// File: rtl/pattern_scheduler_pkg.sv
// rtl/pattern_scheduler_pkg.sv - shared constants and types for the pattern scheduler
package pattern_scheduler_pkg;

  localparam int RGB_W = 12;

  // Board wiring order of the pattern sources on pat_rgb
  localparam int PAT_BARS    = 0;
  localparam int PAT_CHECKER = 1;
  localparam int PAT_GRAD    = 2;
  localparam int PAT_SOLID   = 3;

  typedef enum logic {
    WAIT_SYNC = 1'b0,
    RUN       = 1'b1
  } sched_state_t;

  typedef logic [RGB_W-1:0] rgb_t;

endpackage

// File: rtl/pattern_scheduler_if.sv
// rtl/pattern_scheduler_if.sv - video-side bus between timing/pattern sources and the scheduler
interface pattern_scheduler_if #(
  parameter int NUM_PATTERNS = 4
) ();
  import pattern_scheduler_pkg::*;

  localparam int SEL_W = $clog2(NUM_PATTERNS);

  logic                          frame_start;
  logic                          de;
  logic [RGB_W*NUM_PATTERNS-1:0] pat_rgb;
  logic [RGB_W-1:0]              rgb_out;
  logic [SEL_W-1:0]              pat_sel;
  logic                          sel_change;

  modport master (
    output frame_start, de, pat_rgb,
    input  rgb_out, pat_sel, sel_change
  );

  modport slave (
    input  frame_start, de, pat_rgb,
    output rgb_out, pat_sel, sel_change
  );

endinterface

// File: rtl/pattern_scheduler_btn_debounce.sv
// rtl/pattern_scheduler_btn_debounce.sv - push-button synchroniser, debouncer and press detector
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  // Counter runs only while the synchronised input disagrees with the accepted level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      press <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync[1];
        press <= sync[1];
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pattern_scheduler.sv
// rtl/pattern_scheduler.sv - selects the active test pattern and switches it only at frame boundaries
module pattern_scheduler
  import pattern_scheduler_pkg::*;
#(
  parameter int NUM_PATTERNS       = 4,
  parameter int FRAMES_PER_PATTERN = 60,
  parameter int DEBOUNCE_CYCLES    = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_next,
  input  logic auto_en,
  pattern_scheduler_if.slave bus
);

  localparam int SEL_W = $clog2(NUM_PATTERNS);
  localparam int CNT_W = $clog2(FRAMES_PER_PATTERN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_PATTERN - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_PATTERNS - 1);

  sched_state_t     state;
  logic [SEL_W-1:0] pat_sel;
  logic [SEL_W-1:0] next_sel;
  logic [SEL_W-1:0] effective_sel;
  logic [CNT_W-1:0] frame_cnt;
  logic             pending;
  logic             sel_change;
  rgb_t             rgb_out;
  logic             btn_level;
  logic             btn_press;
  logic             auto_tc;
  logic             advance;
  logic             show;
  rgb_t             src [NUM_PATTERNS];

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_next),
    .level (btn_level),
    .press (btn_press)
  );

  for (genvar i = 0; i < NUM_PATTERNS; i++) begin : g_src
    assign src[i] = bus.pat_rgb[i*RGB_W +: RGB_W];
  end

  // The advancing frame_start cycle already renders pixel (0,0) from the new source
  always_comb begin
    next_sel      = (pat_sel == SEL_LAST) ? '0 : pat_sel + SEL_W'(1);
    auto_tc       = auto_en && (frame_cnt == CNT_LAST);
    advance       = (state == RUN) && bus.frame_start && (pending || auto_tc);
    effective_sel = advance ? next_sel : pat_sel;
    show          = ((state == RUN) || bus.frame_start) && bus.de;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= WAIT_SYNC;
      pat_sel    <= '0;
      pending    <= 1'b0;
      frame_cnt  <= '0;
      sel_change <= 1'b0;
      rgb_out    <= '0;
    end else begin
      sel_change <= advance;
      rgb_out    <= show ? src[effective_sel] : '0;
      case (state)
        WAIT_SYNC: begin
          if (bus.frame_start) state <= RUN;
        end
        RUN: begin
          if (advance) pat_sel <= next_sel;
          // A press landing on an advancing frame_start belongs to the new frame
          if (btn_press && btn_level) pending <= 1'b1;
          else if (advance)           pending <= 1'b0;
          if (!auto_en || advance)    frame_cnt <= '0;
          else if (bus.frame_start)   frame_cnt <= frame_cnt + CNT_W'(1);
        end
      endcase
    end
  end

  assign bus.rgb_out    = rgb_out;
  assign bus.pat_sel    = pat_sel;
  assign bus.sel_change = sel_change;

endmodule
